// File: rtl/mtm_alu_deserializer.sv
// Serial-to-parallel receiver for MTM ALU result packets: 4 data frames + 1 ctl frame, or a lone ctl error frame.
// Optional inter-frame idle timeout compiled in with `define RX_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mtm_alu_deserializer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sin,
  output logic [31:0] C_out,
  output logic [7:0]  CTL_out,
  output logic        valid_out,
  output logic        err_pkt_out,
  output logic        proto_err_out
);

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    DATA,
    STOP,
    RESYNC
  } state_t;

  state_t      state_q, state_d;
  logic        type_q, type_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] c_asm_q, c_asm_d;
  logic [31:0] c_out_q, c_out_d;
  logic [7:0]  ctl_out_q, ctl_out_d;
  logic        valid_q, valid_d;
  logic        err_pkt_q, err_pkt_d;
  logic        proto_err_q, proto_err_d;

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  // The limit only matters when the timeout counter is compiled in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    byte_cnt_d  = byte_cnt_q;
    c_asm_d     = c_asm_q;
    c_out_d     = c_out_q;
    ctl_out_d   = ctl_out_q;
    valid_d     = 1'b0;
    err_pkt_d   = 1'b0;
    proto_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!sin) state_d = TYPE;
      end
      TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
        state_d   = DATA;
      end
      DATA: begin
        byte_d    = {byte_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        if (sin) begin
          state_d = IDLE;
          if (!type_q) begin
            if (byte_cnt_q < 3'd4) begin
              case (byte_cnt_q[1:0])
                2'd0:    c_asm_d[31:24] = byte_q;
                2'd1:    c_asm_d[23:16] = byte_q;
                2'd2:    c_asm_d[15:8]  = byte_q;
                default: c_asm_d[7:0]   = byte_q;
              endcase
              byte_cnt_d = byte_cnt_q + 3'd1;
            end else begin
              // A fifth data frame means the ctl frame was lost; drop everything.
              proto_err_d = 1'b1;
              byte_cnt_d  = 3'd0;
            end
          end else if (byte_cnt_q == 3'd4) begin
            valid_d    = 1'b1;
            c_out_d    = c_asm_q;
            ctl_out_d  = byte_q;
            byte_cnt_d = 3'd0;
          end else if (byte_cnt_q == 3'd0) begin
            valid_d   = 1'b1;
            err_pkt_d = 1'b1;
            c_out_d   = 32'd0;
            ctl_out_d = byte_q;
          end else begin
            proto_err_d = 1'b1;
            byte_cnt_d  = 3'd0;
          end
        end else begin
          proto_err_d = 1'b1;
          byte_cnt_d  = 3'd0;
          state_d     = RESYNC;
        end
      end
      RESYNC: begin
        if (sin) state_d = IDLE;
      end
      default: state_d = RESYNC;
    endcase

`ifdef RX_TIMEOUT_EN
    // Counts consecutive idle-high cycles while a packet is partially received.
    to_cnt_d = '0;
    if (state_q == IDLE && sin && byte_cnt_q != 3'd0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        proto_err_d = 1'b1;
        byte_cnt_d  = 3'd0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESYNC;
      type_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      byte_q      <= 8'd0;
      byte_cnt_q  <= 3'd0;
      c_asm_q     <= 32'd0;
      c_out_q     <= 32'd0;
      ctl_out_q   <= 8'd0;
      valid_q     <= 1'b0;
      err_pkt_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      byte_cnt_q  <= byte_cnt_d;
      c_asm_q     <= c_asm_d;
      c_out_q     <= c_out_d;
      ctl_out_q   <= ctl_out_d;
      valid_q     <= valid_d;
      err_pkt_q   <= err_pkt_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`endif

  assign C_out         = c_out_q;
  assign CTL_out       = ctl_out_q;
  assign valid_out     = valid_q;
  assign err_pkt_out   = err_pkt_q;
  assign proto_err_out = proto_err_q;

endmodule

// File: doc/mtm_alu_deserializer.md
MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the inter-frame idle limit in clk cycles when timeout is compiled in.
REQ-002 clk  input  1  clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 sin  input  1  serial line; idles high; one bit per clk.
REQ-005 C_out  output  32  received result word.
REQ-006 CTL_out  output  8  received control/status byte.
REQ-007 valid_out  output  1  one-cycle pulse; C_out/CTL_out/err_pkt_out are valid when high.
REQ-008 err_pkt_out  output  1  high with valid_out when the packet was a single-CTL error packet.
REQ-009 proto_err_out  output  1  one-cycle pulse on any framing or sequence violation.

Function
REQ-010 Each frame SHALL be 11 bits: start(0), type(0=data, 1=ctl), 8 payload bits MSB first, stop(1).
REQ-011 A normal packet SHALL be 4 data frames (C[31:24] first, C[7:0] last) followed by 1 ctl frame.
REQ-012 An error packet SHALL be exactly 1 ctl frame with no preceding data frames.
REQ-013 FSM states SHALL be IDLE, TYPE, DATA, STOP, RESYNC.
REQ-014 IDLE: sin=0 sampled -> TYPE; sin=1 -> stay.
REQ-015 TYPE: latch sin as frame type, clear bit counter -> DATA.
REQ-016 DATA: shift sin into the byte register for 8 cycles (3-bit counter 0..7) -> STOP after bit 7.
REQ-017 STOP: sin=1 -> frame accepted, IDLE; sin=0 -> proto error, byte counter cleared, RESYNC.
REQ-018 RESYNC: stay until sin=1 sampled, then IDLE.
REQ-019 Accepted data frame with byte counter 0..3: store byte into C slot, increment counter (3-bit, values 0..4).
REQ-020 Accepted data frame with byte counter 4: proto error, packet discarded, counter cleared.
REQ-021 Accepted ctl frame with counter 4: C_out<=assembled word, CTL_out<=byte, err_pkt_out=0, valid_out pulse, counter cleared.
REQ-022 Accepted ctl frame with counter 0: C_out<=0, CTL_out<=byte, err_pkt_out=1, valid_out pulse.
REQ-023 Accepted ctl frame with counter 1..3: proto error, packet discarded, counter cleared, outputs unchanged.
REQ-024 Latency: valid_out/proto_err_out SHALL be high in the cycle immediately after the edge sampling the stop bit.
REQ-025 valid_out and proto_err_out SHALL never be high in the same cycle.
REQ-026 C_out/CTL_out SHALL hold their values until the next valid_out.
REQ-027 Back-to-back frames (start bit directly after stop bit) SHALL be accepted with no idle gap.

Reset
REQ-028 While reset=1: state=RESYNC, counters 0, C_out=0, CTL_out=0, all pulse outputs 0; sin ignored.
REQ-029 After reset release, a start bit SHALL only be accepted after sin=1 has been sampled at least once.
REQ-030 Reset asserted mid-frame or mid-packet SHALL discard partial data with no pulse output.

Configuration
REQ-031 Macro RX_TIMEOUT_EN SHALL compile in an inter-frame timeout counter.
REQ-032 With RX_TIMEOUT_EN: in IDLE with byte counter 1..4, TIMEOUT_CYCLES consecutive sin=1 cycles SHALL pulse proto_err_out and clear the counter; the counter restarts on every accepted frame.
REQ-033 Without RX_TIMEOUT_EN: no timeout logic; a partial packet SHALL wait in IDLE indefinitely.

Verification
REQ-034 Normal packet C=0xF322ACAA, CTL=0x2A, frames back-to-back -> one valid_out, C_out=0xF322ACAA, CTL_out=0x2A, err_pkt_out=0, 55 bits + 1 cycle latency.
REQ-035 Error packet ctl frame 0xC9 -> valid_out, err_pkt_out=1, CTL_out=0xC9, C_out=0x00000000.
REQ-036 Data frame 0x12 with stop bit 0, then sin held low 5 cycles, then high -> one proto_err_out, no valid_out, next normal packet decodes correctly.
REQ-037 Two data frames followed by ctl frame 0x2A -> proto_err_out pulse, C_out/CTL_out unchanged from prior packet.
REQ-038 Reset pulsed during 3rd data frame, then full packet C=0x00000001, CTL=0x40 -> no pulse before, valid_out with those values after.
REQ-039 RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: one data frame then 16 idle cycles -> proto_err_out pulse; with macro undefined -> no pulse.
